// File: rtl/layer_sequencer.sv
// layer_sequencer: clear/fetch/drain/bias/activate/output schedule for one FC layer pass; start-to-outValid
// is numInputs+memLatency+actLatency+3 cycles plus stalls. inValid low stalls fetch; outValid holds until outReady.
module layer_sequencer #(
   parameter int numInputs    = 16,
   parameter int memLatency   = 1,
   parameter int actLatency   = 1,
   parameter int counterWidth = $clog2(numInputs + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    inValid,
   input  logic                    outReady,
   output logic [counterWidth-1:0] inAddr,
   output logic                    macClear,
   output logic                    macEn,
   output logic                    biasEn,
   output logic                    actEn,
   output logic                    outValid,
   output logic                    busy,
   output logic                    done
);

   localparam int MaxCnt = (memLatency > actLatency) ? memLatency : actLatency;
   localparam int CntW   = $clog2(MaxCnt + 1);
   localparam logic [counterWidth-1:0] LastAddr  = counterWidth'(numInputs - 1);
   localparam logic [CntW-1:0]         DrainLast = CntW'((memLatency > 0) ? memLatency - 1 : 0);
   localparam logic [CntW-1:0]         ActLast   = CntW'(actLatency - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, BIAS, ACT, OUT} state_t;

   state_t                  state_q, state_d;
   logic                    pend_q, pend_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [counterWidth-1:0] addr_q, addr_d;
   logic                    clr_q, clr_d;
   logic                    bias_q, bias_d;
   logic                    act_q, act_d;
   logic                    ov_q, ov_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    issue;

   assign issue = (state_q == FETCH) && inValid;

   always_comb begin
      state_d = state_q;
      pend_d  = 1'b0;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            addr_d = '0;
            // A start seen while inValid is low waits here until data shows up
            if ((start || pend_q) && inValid) state_d = CLEAR;
            else pend_d = start || pend_q;
         end
         CLEAR: begin
            addr_d  = '0;
            state_d = FETCH;
         end
         FETCH: begin
            if (inValid) begin
               if (addr_q == LastAddr) begin
                  addr_d  = '0;
                  cnt_d   = '0;
                  state_d = (memLatency == 0) ? BIAS : DRAIN;
               end else begin
                  addr_d = addr_q + counterWidth'(1);
               end
            end
         end
         DRAIN: begin
            if (cnt_q == DrainLast) state_d = BIAS;
            else cnt_d = cnt_q + CntW'(1);
         end
         BIAS: begin
            cnt_d   = '0;
            state_d = ACT;
         end
         ACT: begin
            if (cnt_q == ActLast) state_d = OUT;
            else cnt_d = cnt_q + CntW'(1);
         end
         OUT: begin
            if (outReady) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Strobes are decoded from the next state so every output comes straight off a flop
      clr_d  = (state_d == CLEAR);
      bias_d = (state_d == BIAS);
      act_d  = (state_d == ACT);
      ov_d   = (state_d == OUT);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         clr_q   <= 1'b0;
         bias_q  <= 1'b0;
         act_q   <= 1'b0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         clr_q   <= clr_d;
         bias_q  <= bias_d;
         act_q   <= act_d;
         ov_q    <= ov_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // macEn follows issue by the memory read latency so it lines up with returning data
   generate
      if (memLatency == 0) begin : g_nopipe
         assign macEn = issue;
      end else begin : g_pipe
         logic [memLatency-1:0] pipe_q, pipe_d;
         always_comb begin
            pipe_d    = pipe_q << 1;
            pipe_d[0] = issue;
         end
         always_ff @(posedge clk or posedge reset) begin
            if (reset) pipe_q <= '0;
            else       pipe_q <= pipe_d;
         end
         assign macEn = pipe_q[memLatency-1];
      end
   endgenerate

   assign inAddr   = addr_q;
   assign macClear = clr_q;
   assign biasEn   = bias_q;
   assign actEn    = act_q;
   assign outValid = ov_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
